hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Drives the stall/enable side of the REG->EXE pipeline register and the upstream stage registers.
//  Tracks in-flight destinations (EXE/MEM/WB) and detects RAW hazards on REG-stage sources Ra/Rb.
//  Freezes the front end and inserts bubbles on hazards; holds EXE while the multi-cycle filter unit runs.
//  Sits beside the REG stage; consumes REG-stage decode fields, produces hold/bubble/forward selects.
// PARAMETERS
//  REG_W       4    register index width
//  MC_TIMEOUT  64   max cycles in BUSY before o_mc_err; counter width = $clog2(MC_TIMEOUT+1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  i_Ra       in   REG_W  source A index of instruction in REG stage
//  i_Rb       in   REG_W  source B index of instruction in REG stage
//  i_useA     in   1      instruction reads Ra
//  i_useB     in   1      instruction reads Rb
//  i_Robj     in   REG_W  destination index of instruction in REG stage
//  i_wr       in   1      instruction writes Robj
//  i_load     in   1      instruction is a load (result available after MEM)
//  i_mc       in   1      instruction uses multi-cycle filter unit
//  i_mc_done  in   1      filter unit finished (sampled only in BUSY)
//  o_hold     out  1      hold IF and REG stage registers
//  o_bubble   out  1      zero ctrl entering REG->EXE register
//  o_exe_en   out  1      REG->EXE register EN (1 = hold, register's own polarity)
//  o_fwdA     out  2      Ra source: 00 regfile, 01 EXE, 10 MEM, 11 WB
//  o_fwdB     out  2      Rb source, same encoding
//  o_mc_err   out  1      sticky: multi-cycle timeout occurred
// BEHAVIOUR
//  - Reset: scoreboard all invalid, FSM IDLE, counter 0, o_mc_err 0 -> all outputs 0.
//  - Scoreboard: 3 entries {valid,dest,load,mc} for EXE, MEM, WB. Dest 0 never marked valid (R0 is constant zero).
//  - Hazard match: useX && entry.valid && entry.dest==RX && RX!=0.
//  - o_hold/o_bubble/o_fwd* combinational from registered scoreboard/FSM + current inputs; zero-cycle reaction.
//  - IDLE, no stall: each clk shifts EXE<-REG (valid = i_wr & Robj!=0), MEM<-EXE, WB<-MEM.
//  - Stall (IDLE): o_hold=1, o_bubble=1, o_exe_en=0; EXE gets invalid entry, MEM/WB shift normally.
//  - FSM IDLE->BUSY when EXE entry has mc=1 (entered previous cycle); counter cleared.
//  - BUSY: o_hold=1, o_exe_en=1, o_bubble=0; EXE entry frozen; MEM<-invalid; WB<-MEM; counter++ each cycle.
//  - BUSY->IDLE on i_mc_done (EXE advances to MEM that edge) or counter==MC_TIMEOUT (set o_mc_err, advance identically).
//  - i_mc_done in IDLE ignored. BUSY takes priority over any RAW stall.
//  - Async reset mid-BUSY: immediate return to IDLE, scoreboard cleared; o_mc_err cleared only by reset.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: stall only on load-use (EXE entry load=1 and match), 1 bubble;
//   otherwise o_fwdX selects youngest matching entry (EXE>MEM>WB).
//  Undefined: o_fwdA/o_fwdB tied 00; stall while any valid entry matches (up to 3 bubbles).
// STRUCTURE
//  proc_pkg: REG_W constant, fwd_sel_e (FWD_RF/EXE/MEM/WB), hsc_state_e (HSC_IDLE/HSC_BUSY), sb_entry_t struct.
//  Sub-module hazard_scoreboard: 3-entry shift with shift/freeze/insert-bubble controls and match outputs.
// TESTING
//  - Reset held, toggle inputs -> all outputs 0; release, issue ADD R3 (wr) -> EXE entry valid dest 3 next cycle.
//  - Fwd on: ADD R3 then SUB uses Ra=3 -> o_fwdA=01, no hold; two gaps later -> o_fwdA=11.
//  - Fwd on: LOAD R5 then use Rb=5 -> o_hold=o_bubble=1 one cycle, then o_fwdB=10, no hold.
//  - Fwd off: ADD R3 then use Ra=3 -> o_hold 3 cycles, then o_fwdA=00; write to R0 then use R0 -> no hold.
//  - mc instr, i_mc_done at BUSY cycle 5 -> o_exe_en=1 & o_hold=1 for 5 cycles, IDLE next; done in IDLE ignored.
//  - MC_TIMEOUT=8, no done -> IDLE after 8 BUSY cycles, o_mc_err=1 sticky; rst_n low mid-BUSY -> all 0 at once.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types for the REG-stage hazard/stall controller: scoreboard entry,
// forward-select encoding, controller states and small match helpers.
package proc_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    HSC_IDLE = 1'b0,
    HSC_BUSY = 1'b1
  } hsc_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             load;
    logic             mc;
  } sb_entry_t;

  // R0 is constant zero, so a read of R0 never depends on an in-flight write.
  function automatic logic sb_hit(input sb_entry_t e, input logic use_r,
                                  input logic [REG_W-1:0] r);
    return use_r && e.valid && (e.dest == r) && (r != '0);
  endfunction

  // Youngest producer wins: bit 0 = EXE, bit 1 = MEM, bit 2 = WB.
  function automatic fwd_sel_e fwd_pick(input logic [2:0] m);
    if (m[0]) return FWD_EXE;
    if (m[1]) return FWD_MEM;
    if (m[2]) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight destination tracker (EXE/MEM/WB) with freeze and
// bubble-insert controls, plus per-stage RAW match vectors for Ra/Rb.
module hazard_scoreboard
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  sb_entry_t        ins,
  input  logic             freeze,
  input  logic             bubble,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic             use_a,
  input  logic             use_b,
  output logic             ex_load,
  output logic [2:0]       match_a,
  output logic [2:0]       match_b
);

  localparam sb_entry_t SB_EMPTY = '0;

  sb_entry_t ex, mem, wb;

  // freeze: EXE keeps the multi-cycle op, nothing new reaches MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= SB_EMPTY;
      mem <= SB_EMPTY;
      wb  <= SB_EMPTY;
    end else if (freeze) begin
      mem <= SB_EMPTY;
      wb  <= mem;
    end else begin
      ex  <= bubble ? SB_EMPTY : ins;
      mem <= ex;
      wb  <= mem;
    end
  end

  always_comb begin
    match_a = {sb_hit(wb, use_a, ra), sb_hit(mem, use_a, ra), sb_hit(ex, use_a, ra)};
    match_b = {sb_hit(wb, use_b, rb), sb_hit(mem, use_b, rb), sb_hit(ex, use_b, rb)};
  end

  assign ex_load = ex.load;

  logic unused_wb;
  assign unused_wb = ^{wb.load, wb.mc};

endmodule

// File: rtl/hazard_stall_ctrl.sv
// REG-stage hazard and stall controller: RAW stalls/bubbles, forward selects,
// and EXE hold while the multi-cycle filter unit runs. Optional forwarding
// is enabled by defining HAZARD_FORWARDING_EN.
module hazard_stall_ctrl #(
  parameter int REG_W      = proc_pkg::REG_W,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] i_Ra,
  input  logic [REG_W-1:0] i_Rb,
  input  logic             i_useA,
  input  logic             i_useB,
  input  logic [REG_W-1:0] i_Robj,
  input  logic             i_wr,
  input  logic             i_load,
  input  logic             i_mc,
  input  logic             i_mc_done,
  output logic             o_hold,
  output logic             o_bubble,
  output logic             o_exe_en,
  output logic [1:0]       o_fwdA,
  output logic [1:0]       o_fwdB,
  output logic             o_mc_err
);

  import proc_pkg::*;

  localparam int CW = $clog2(MC_TIMEOUT + 1);

  hsc_state_e    state, state_next;
  logic [CW-1:0] cnt;
  sb_entry_t     ins;
  logic          ex_load;
  logic [2:0]    match_a, match_b;
  logic          raw_stall, freeze, sb_bubble, timeout;

  assign ins.valid = i_wr && (i_Robj != '0);
  assign ins.dest  = i_Robj;
  assign ins.load  = i_load;
  assign ins.mc    = i_mc;

  hazard_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .ins     (ins),
    .freeze  (freeze),
    .bubble  (sb_bubble),
    .ra      (i_Ra),
    .rb      (i_Rb),
    .use_a   (i_useA),
    .use_b   (i_useB),
    .ex_load (ex_load),
    .match_a (match_a),
    .match_b (match_b)
  );

`ifdef HAZARD_FORWARDING_EN
  // Only a load still in EXE cannot be forwarded; everything else bypasses.
  assign raw_stall = ex_load && (match_a[0] || match_b[0]);
  assign o_fwdA    = fwd_pick(match_a);
  assign o_fwdB    = fwd_pick(match_b);
`else
  assign raw_stall = (|match_a) || (|match_b);
  assign o_fwdA    = FWD_RF;
  assign o_fwdB    = FWD_RF;
  logic unused_load;
  assign unused_load = ex_load;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HSC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // BUSY starts on the edge the multi-cycle op is accepted into EXE.
  always_comb begin
    state_next = state;
    o_hold     = 1'b0;
    o_bubble   = 1'b0;
    o_exe_en   = 1'b0;
    freeze     = 1'b0;
    sb_bubble  = 1'b0;
    timeout    = 1'b0;
    case (state)
      HSC_IDLE: begin
        o_hold    = raw_stall;
        o_bubble  = raw_stall;
        sb_bubble = raw_stall;
        if (!raw_stall && i_mc) state_next = HSC_BUSY;
      end
      HSC_BUSY: begin
        o_hold   = 1'b1;
        o_exe_en = 1'b1;
        timeout  = (cnt == CW'(MC_TIMEOUT - 1));
        if (i_mc_done || timeout) begin
          state_next = HSC_IDLE;
          sb_bubble  = 1'b1;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_next = HSC_IDLE;
    endcase
  end

  // cnt = BUSY cycles already completed, so the MC_TIMEOUT-th cycle is the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      o_mc_err <= 1'b0;
    end else begin
      cnt <= (state == HSC_BUSY) ? cnt + 1'b1 : '0;
      if (state == HSC_BUSY && timeout && !i_mc_done) o_mc_err <= 1'b1;
    end
  end

endmodule
